// File: rtl/v2k_typedef_yee_pixel_tx.sv
// Pixel-stream transmitter: 2-entry skid buffer feeding a line/frame framer
// with programmable horizontal blanking and valid/ready flow control downstream.
module v2k_typedef_yee_pixel_tx #(
  parameter int HSIZE  = 8,
  parameter int VSIZE  = 4,
  parameter int HBLANK = 2
) (
  input  logic        cp,
  input  logic        reset,
  input  logic        start,
  input  logic [23:0] in_pixel,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [23:0] tx_pixel,
  output logic        tx_valid,
  input  logic        ready,
  output logic        tx_sof,
  output logic        tx_eol,
  output logic        tx_eof,
  output logic        busy,
  output logic        frame_done
);

  typedef logic [23:0] pixel24_t;
  typedef enum logic [1:0] {IDLE, ACTIVE, BLANK, DONE} state_t;

  localparam int XW = (HSIZE > 1) ? $clog2(HSIZE) : 1;
  localparam int YW = (VSIZE > 1) ? $clog2(VSIZE) : 1;
  localparam int BW = (HBLANK > 1) ? $clog2(HBLANK) : 1;
  localparam logic [XW-1:0] XLAST = XW'(HSIZE - 1);
  localparam logic [YW-1:0] YLAST = YW'(VSIZE - 1);
  localparam logic [BW-1:0] BLAST = BW'((HBLANK > 0) ? HBLANK - 1 : 0);

  pixel24_t      mem_q [2];
  logic          wrPtr_q;
  logic          rdPtr_q;
  logic [1:0]    count_q;
  logic [1:0]    count_d;
  logic          inReady_q;
  state_t        state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic [BW-1:0] blank_q;
  logic          push;
  logic          pop;
  logic          xLast;
  logic          yLast;

  assign push       = in_valid & inReady_q;
  assign tx_valid   = (state_q == ACTIVE) && (count_q != 2'd0);
  assign pop        = tx_valid & ready;
  assign in_ready   = inReady_q;
  assign tx_pixel   = tx_valid ? mem_q[rdPtr_q] : '0;
  assign xLast      = (x_q == XLAST);
  assign yLast      = (y_q == YLAST);
  assign tx_sof     = tx_valid && (x_q == '0) && (y_q == '0);
  assign tx_eol     = tx_valid && xLast;
  assign tx_eof     = tx_eol && yLast;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == DONE);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: ;
    endcase
  end

  // in_ready is registered from the next occupancy so it never lags a pop
  always_ff @(posedge cp) begin
    if (reset) begin
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      count_q   <= 2'd0;
      inReady_q <= 1'b1;
    end else begin
      if (push) wrPtr_q <= ~wrPtr_q;
      if (pop)  rdPtr_q <= ~rdPtr_q;
      count_q   <= count_d;
      inReady_q <= (count_d != 2'd2);
    end
  end

  always_ff @(posedge cp) begin
    if (push) mem_q[wrPtr_q] <= in_pixel;
  end

  always_ff @(posedge cp) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      blank_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= ACTIVE;
            x_q     <= '0;
            y_q     <= '0;
          end
        end
        ACTIVE: begin
          if (pop) begin
            if (xLast) begin
              x_q <= '0;
              if (yLast) begin
                state_q <= DONE;
              end else begin
                y_q <= y_q + 1'b1;
                if (HBLANK > 0) begin
                  state_q <= BLANK;
                  blank_q <= '0;
                end
              end
            end else begin
              x_q <= x_q + 1'b1;
            end
          end
        end
        // blanking length is fixed and deliberately ignores downstream ready
        BLANK: begin
          if (blank_q == BLAST) begin
            state_q <= ACTIVE;
            blank_q <= '0;
          end else begin
            blank_q <= blank_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          y_q     <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/v2k_typedef_yee_pixel_tx.md
Name: v2k_typedef_yee_pixel_tx

Overview:
Pixel-stream transmitter that feeds the pixel consumer on the ready-driven side of the yee pixel path. It accepts pixels from an upstream source through a 2-entry skid buffer. It frames them into lines and frames of fixed size, with a programmable horizontal blanking gap, and drives them downstream under valid/ready flow control. It sits between the pixel source (`sub1_out_pixel`-style producer) and the consumer that asserts `ready`.

Parameters:
HSIZE, 8, active pixels per line (>=2)
VSIZE, 4, lines per frame (>=1)
HBLANK, 2, idle cycles inserted after each line (0 = none)

Ports:
cp  input  1  clock, rising edge
reset  input  1  synchronous reset, active-high
start  input  1  single-cycle pulse; begins one frame when idle
in_pixel  input  24  upstream pixel (pixel24_t)
in_valid  input  1  upstream pixel valid
in_ready  output  1  skid buffer can accept
tx_pixel  output  24  downstream pixel (pixel24_t)
tx_valid  output  1  downstream pixel valid
ready  input  1  downstream consumer ready
tx_sof  output  1  first pixel of frame (qualifies tx_valid)
tx_eol  output  1  last pixel of line (qualifies tx_valid)
tx_eof  output  1  last pixel of frame (qualifies tx_valid)
busy  output  1  frame in progress
frame_done  output  1  one-cycle pulse after the eof beat transfers

Behaviour:
- Reset: all outputs 0, except `in_ready` = 1. The skid buffer is emptied, state = IDLE, and x/y counters = 0. Reset mid-frame aborts immediately; no partial-frame completion.
- Upstream transfer: `in_valid & in_ready`. `in_ready` = buffer count < 2, registered. The upstream side is independent of FSM state, so prefetch during IDLE/HBLANK is allowed.
- Downstream transfer: `tx_valid & ready`. `tx_valid` = (state == ACTIVE) & buffer non-empty. `tx_pixel` is the buffer head, and is stable while `tx_valid & !ready`.
- Buffer: 2-entry FIFO. Simultaneous push and pop at count 2 is not possible, because `in_ready` is 0. At count 1, push and pop together keep count at 1 and the data advances. A pop is never taken from an empty buffer.
- Zero-bubble rule: with the buffer fed continuously and `ready` held at 1, one pixel transfers per cycle within a line.
- FSM:
  - IDLE: `busy` = 0. On `start`, go to ACTIVE with x = 0, y = 0. `start` in any other state is ignored.
  - ACTIVE: each downstream transfer does x++.
    - On the transfer with x == HSIZE-1: x is set to 0.
    - If y == VSIZE-1, go to DONE.
    - Else y++, then go to HBLANK if HBLANK > 0, or stay in ACTIVE if HBLANK == 0.
  - HBLANK: a counter runs HBLANK cycles with `tx_valid` forced 0, then returns to ACTIVE.
  - DONE: `frame_done` = 1 for exactly one cycle, then go to IDLE. `busy` = 1 in ACTIVE, HBLANK and DONE.
- Markers are combinational from the counters and valid only with `tx_valid`:
  - `tx_sof` = (x==0 & y==0).
  - `tx_eol` = (x==HSIZE-1).
  - `tx_eof` = `tx_eol` & (y==VSIZE-1).
- Backpressure: `ready` low holds x, y, state and `tx_pixel`. The blanking counter is not affected by `ready`.
- Counter widths: x = $clog2(HSIZE), y = $clog2(VSIZE) (minimum 1 bit). There is no wrap beyond HSIZE-1 or VSIZE-1.
- Upstream starvation (buffer empty in ACTIVE): `tx_valid` = 0 and the counters hold. The frame resumes when data arrives; no timeout.

Test Plan:
- Continuous frame: reset, `ready` = 1, upstream streams 0x000001, 0x000002, … then `start` -> 32 beats total (HSIZE=8, VSIZE=4).
  - `tx_sof` on 0x000001 only; `tx_eol` on pixels 8, 16, 24, 32; `tx_eof` on 32.
  - Exactly 2 idle cycles after each of the first 3 lines; `frame_done` one cycle after the beat-32 transfer.
- Backpressure: toggle `ready` 1,0,0,1 repeatedly -> `tx_pixel` stable whenever `ready` = 0; sequence delivered in order, no drop or duplicate.
- Skid full: `ready` = 0, `in_valid` = 1 -> `in_ready` drops after 2 accepts. Release `ready` -> first two pixels emitted back-to-back.
- Starvation: `in_valid` deasserted for 5 cycles at x=3 -> `tx_valid` = 0 for those cycles; the next beat carries x=3 data with no marker shift.
- Start ignored while busy and reset mid-frame: `start` pulsed at y=1 has no effect. `reset` at y=2, x=5 -> next cycle `busy` = 0, `tx_valid` = 0, `in_ready` = 1; a new `start` produces `tx_sof` on the first beat.
- HBLANK=0 configuration -> the last pixel of line 0 and the first pixel of line 1 transfer in consecutive cycles.
